// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

  localparam int unsigned MAX_LEN_DEF = 8;
  localparam int unsigned LEN_W       = $clog2(MAX_LEN_DEF + 1);

  typedef struct packed {
    logic [MAX_LEN_DEF-1:0] pat;
    logic [LEN_W-1:0]       len;
    logic                   overlap;
  } cfg_t;

  function automatic int unsigned clamp_len(int unsigned len, int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating event counter; a clear coinciding with an increment leaves a count of one.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         sat_o
);

  logic [W-1:0] cnt_n;

  always_comb begin
    cnt_n = cnt_o;
    if (clr_i) begin
      cnt_n = inc_i ? W'(1) : '0;
    end else if (inc_i && !(&cnt_o)) begin
      cnt_n = cnt_o + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_o <= '0;
      sat_o <= 1'b0;
    end else begin
      cnt_o <= cnt_n;
      sat_o <= &cnt_n;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial bit-pattern detector with overlap control and saturating hit counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned           MAX_LEN     = 8,
  parameter int unsigned           CNT_W       = 8,
  parameter logic [MAX_LEN-1:0]    RST_PAT     = MAX_LEN'(8'b0000_1101),
  parameter int unsigned           RST_LEN     = 4,
  parameter logic                  RST_OVERLAP = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en_i,
  input  logic                           x_i,
  input  logic                           cfg_we_i,
  input  logic [MAX_LEN-1:0]             cfg_pat_i,
  input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len_i,
  input  logic                           cfg_overlap_i,
  input  logic                           cnt_clr_i,
  output logic                           det_o,
  output logic [CNT_W-1:0]               det_cnt_o,
  output logic                           cnt_sat_o
);

  localparam int unsigned LW = $clog2(MAX_LEN + 1);

  logic [MAX_LEN-1:0] pat_q, hist, hist_n, mask;
  logic [LW-1:0]      len_q, fill, fill_n, len_ld;
  logic               ovl_q, match;

  always_comb begin
    hist_n = {hist[MAX_LEN-2:0], x_i};
    fill_n = (fill == LW'(MAX_LEN)) ? fill : fill + 1'b1;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < 32'(len_q));
    end
    match  = en_i && !cfg_we_i && (len_q != '0) && (fill_n >= len_q) &&
             (((hist_n ^ pat_q) & mask) == '0);
    len_ld = LW'(clamp_len(32'(cfg_len_i), MAX_LEN));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q <= RST_PAT;
      len_q <= LW'(clamp_len(RST_LEN, MAX_LEN));
      ovl_q <= RST_OVERLAP;
      hist  <= '0;
      fill  <= '0;
      det_o <= 1'b0;
    end else if (cfg_we_i) begin
      pat_q <= cfg_pat_i;
      len_q <= len_ld;
      ovl_q <= cfg_overlap_i;
      hist  <= '0;
      fill  <= '0;
      det_o <= 1'b0;
    end else if (en_i) begin
      hist  <= hist_n;
      // Non-overlap: zeroing fill forces len_q fresh bits before the next hit.
      fill  <= (match && !ovl_q) ? '0 : fill_n;
      det_o <= match;
    end else begin
      det_o <= 1'b0;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (match),
    .clr_i (cnt_clr_i),
    .cnt_o (det_cnt_o),
    .sat_o (cnt_sat_o)
  );

endmodule
